// File: rtl/param_frame_tx_if.sv
// Word-input handshake for param_frame_tx: the source drives {id, data} under valid/ready.
// Widths must match the parameters of the param_frame_tx instance this bundle connects to.
interface param_frame_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [ID_WIDTH-1:0]   in_id;

  modport master (output in_valid, output in_data, output in_id, input in_ready);
  modport slave  (input in_valid, input in_data, input in_id, output in_ready);
endinterface

// File: rtl/param_frame_tx.sv
// Tagged-word serial transmitter: frames each accepted {id, data} word as
// start(0), id LSB-first, data LSB-first, even parity, stop(1), each bit CLKS_PER_BIT cycles.
module param_frame_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  param_frame_tx_if.slave  in_if,
  output logic             tx_line,
  output logic             busy,
  output logic             done
);

  localparam int CNT_M  = (CLKS_PER_BIT < 2) ? 2 : CLKS_PER_BIT;
  localparam int BIT_MX = (ID_WIDTH > DATA_WIDTH) ? ID_WIDTH : DATA_WIDTH;
  localparam int BIT_M  = (BIT_MX < 2) ? 2 : BIT_MX;
  localparam int CNT_W  = $clog2(CNT_M);
  localparam int BIT_W  = $clog2(BIT_M);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] ID_LAST  = BIT_W'(ID_WIDTH - 1);
  localparam logic [BIT_W-1:0] DAT_LAST = BIT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_ID     = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  logic [2:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [BIT_W-1:0]      bit_idx;
  logic [ID_WIDTH-1:0]   id_sr;
  logic [DATA_WIDTH-1:0] data_sr;
  logic [ID_WIDTH-1:0]   id_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic                  parity;
  logic                  ready_en;
  logic                  accept;

  // ready_en keeps in_ready low until the first edge after reset is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign in_if.in_ready = ready_en && (state == S_IDLE);
  assign busy           = (state != S_IDLE);
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign id_next        = id_sr >> 1;
  assign data_next      = data_sr >> 1;

  // tx_line is loaded with the level of the bit being entered, so it is purely registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      id_sr   <= '0;
      data_sr <= '0;
      parity  <= 1'b0;
      tx_line <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (accept) begin
          state   <= S_START;
          cnt     <= '0;
          bit_idx <= '0;
          id_sr   <= in_if.in_id;
          data_sr <= in_if.in_data;
          parity  <= ^{in_if.in_id, in_if.in_data};
          tx_line <= 1'b0;
        end
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
        case (state)
          S_START: begin
            state   <= S_ID;
            tx_line <= id_sr[0];
          end
          S_ID: begin
            if (bit_idx == ID_LAST) begin
              state   <= S_DATA;
              bit_idx <= '0;
              tx_line <= data_sr[0];
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              id_sr   <= id_next;
              tx_line <= id_next[0];
            end
          end
          S_DATA: begin
            if (bit_idx == DAT_LAST) begin
              state   <= S_PARITY;
              bit_idx <= '0;
              tx_line <= parity;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              data_sr <= data_next;
              tx_line <= data_next[0];
            end
          end
          S_PARITY: begin
            state   <= S_STOP;
            tx_line <= 1'b1;
          end
          S_STOP: begin
            state   <= S_IDLE;
            done    <= 1'b1;
            tx_line <= 1'b1;
          end
          default: begin
            state   <= S_IDLE;
            tx_line <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_param_frame_tx.sv
// Bench for param_frame_tx: two instances (8/4/2 and 32/8/1) checked cycle by cycle
// against a frame model built from the bit-level frame format.
module tb_param_frame_tx;

  logic clk;
  logic rst_n;
  logic a_tx, a_busy, a_done;
  logic b_tx, b_busy, b_done;
  int   n_pass;
  int   n_total;

  param_frame_tx_if #(.DATA_WIDTH(8),  .ID_WIDTH(4)) a_if ();
  param_frame_tx_if #(.DATA_WIDTH(32), .ID_WIDTH(8)) b_if ();

  param_frame_tx #(.DATA_WIDTH(8), .ID_WIDTH(4), .CLKS_PER_BIT(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_if(a_if.slave),
    .tx_line(a_tx), .busy(a_busy), .done(a_done)
  );

  param_frame_tx #(.DATA_WIDTH(32), .ID_WIDTH(8), .CLKS_PER_BIT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_if(b_if.slave),
    .tx_line(b_tx), .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Frame as a bit vector, bit 0 transmitted first
  function automatic logic [63:0] frame_of(input int unsigned idw, input int unsigned dw,
                                           input logic [63:0] id, input logic [63:0] d);
    logic [63:0] f;
    int unsigned ones;
    ones = $countones(id) + $countones(d);
    f = 64'd0;
    f = f | (id << 1);
    f = f | (d << (idw + 1));
    f[idw + dw + 1] = ones[0];
    f[idw + dw + 2] = 1'b1;
    return f;
  endfunction

  // Precondition: at a negedge with the word already presented on a_if.
  task automatic run_a(input string tag, input logic [3:0] id, input logic [7:0] d,
                       input logic nvalid, input logic [3:0] nid, input logic [7:0] nd,
                       input bit disturb);
    logic [63:0] f;
    int unsigned n;
    f = frame_of(4, 8, {60'd0, id}, {56'd0, d});
    n = 15 * 2;
    chk({tag, "_ready"}, {63'd0, a_if.in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    a_if.in_valid = nvalid;
    a_if.in_id    = nid;
    a_if.in_data  = nd;
    for (int unsigned k = 0; k < n; k++) begin
      if (disturb && (k / 2) >= 5 && (k / 2) < 13) a_if.in_data = 8'hFF;
      chk(tag, {60'd0, a_tx, a_busy, a_done, a_if.in_ready}, {60'd0, f[k / 2], 3'b100});
      @(negedge clk);
    end
    chk({tag, "_done"}, {60'd0, a_tx, a_busy, a_done, a_if.in_ready}, {60'd0, 4'b1011});
  endtask

  task automatic run_b(input string tag, input logic [7:0] id, input logic [31:0] d);
    logic [63:0] f;
    f = frame_of(8, 32, {56'd0, id}, {32'd0, d});
    b_if.in_valid = 1'b1;
    b_if.in_id    = id;
    b_if.in_data  = d;
    chk({tag, "_ready"}, {63'd0, b_if.in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    b_if.in_valid = 1'b0;
    for (int unsigned k = 0; k < 43; k++) begin
      chk(tag, {60'd0, b_tx, b_busy, b_done, b_if.in_ready}, {60'd0, f[k], 3'b100});
      @(negedge clk);
    end
    chk({tag, "_done"}, {60'd0, b_tx, b_busy, b_done, b_if.in_ready}, {60'd0, 4'b1011});
    @(negedge clk);
    chk({tag, "_idle"}, {60'd0, b_tx, b_busy, b_done, b_if.in_ready}, {60'd0, 4'b1001});
  endtask

  initial begin
    logic [3:0] rid0, rid1;
    logic [7:0] rd0, rd1;
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_id = '0; a_if.in_data = '0;
    b_if.in_valid = 1'b0; b_if.in_id = '0; b_if.in_data = '0;

    // Reset held 3 cycles, then released
    repeat (3) begin
      @(negedge clk);
      chk("rst_a", {60'd0, a_tx, a_busy, a_done, a_if.in_ready}, {60'd0, 4'b1000});
      chk("rst_b", {60'd0, b_tx, b_busy, b_done, b_if.in_ready}, {60'd0, 4'b1000});
    end
    rst_n = 1'b1;
    #1;
    chk("rel_ready_low", {63'd0, a_if.in_ready}, 64'd0);
    @(negedge clk);
    chk("rel_ready_high", {60'd0, a_tx, a_busy, a_done, a_if.in_ready}, {60'd0, 4'b1001});
    repeat (3) begin
      @(negedge clk);
      chk("idle_a", {60'd0, a_tx, a_busy, a_done, a_if.in_ready}, {60'd0, 4'b1001});
    end

    // Basic frame, then odd-parity frame
    a_if.in_valid = 1'b1; a_if.in_id = 4'hA; a_if.in_data = 8'h3C;
    run_a("basic", 4'hA, 8'h3C, 1'b0, 4'h0, 8'h00, 1'b0);
    @(negedge clk);
    a_if.in_valid = 1'b1; a_if.in_id = 4'h0; a_if.in_data = 8'h07;
    run_a("oddpar", 4'h0, 8'h07, 1'b0, 4'h0, 8'h00, 1'b0);
    @(negedge clk);
    chk("idle_after", {60'd0, a_tx, a_busy, a_done, a_if.in_ready}, {60'd0, 4'b1001});

    // Back-to-back: in_valid stays high across both words
    a_if.in_valid = 1'b1; a_if.in_id = 4'hA; a_if.in_data = 8'h3C;
    run_a("b2b_1", 4'hA, 8'h3C, 1'b1, 4'h0, 8'h07, 1'b0);
    run_a("b2b_2", 4'h0, 8'h07, 1'b0, 4'h0, 8'h00, 1'b0);
    @(negedge clk);

    // Data input changed mid-frame must not disturb the frame
    a_if.in_valid = 1'b1; a_if.in_id = 4'h5; a_if.in_data = 8'h96;
    run_a("disturb", 4'h5, 8'h96, 1'b0, 4'h5, 8'h96, 1'b1);
    @(negedge clk);

    // Randomized back-to-back pairs
    for (int unsigned r = 0; r < 4; r++) begin
      rid0 = 4'($urandom); rd0 = 8'($urandom);
      rid1 = 4'($urandom); rd1 = 8'($urandom);
      a_if.in_valid = 1'b1; a_if.in_id = rid0; a_if.in_data = rd0;
      run_a("rand_1", rid0, rd0, 1'b1, rid1, rd1, 1'b0);
      run_a("rand_2", rid1, rd1, 1'b0, 4'h0, 8'h00, 1'b0);
      @(negedge clk);
    end

    // Wide instance
    run_b("wide", 8'h01, 32'h8000_0001);
    run_b("wide_rand", 8'($urandom), $urandom);

    // Reset asserted during the DATA state
    a_if.in_valid = 1'b1; a_if.in_id = 4'hC; a_if.in_data = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    a_if.in_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_rst_busy", {63'd0, a_busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst", {60'd0, a_tx, a_busy, a_done, a_if.in_ready}, {60'd0, 4'b1000});
    repeat (2) begin
      @(negedge clk);
      chk("midrst_hold", {60'd0, a_tx, a_busy, a_done, a_if.in_ready}, {60'd0, 4'b1000});
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int unsigned k = 0; k < 40; k++) begin
      chk("no_resume", {60'd0, a_tx, a_busy, a_done, a_if.in_ready}, {60'd0, 4'b1001});
      @(negedge clk);
    end

    // Fresh frame after the abandoned one
    a_if.in_valid = 1'b1; a_if.in_id = 4'h3; a_if.in_data = 8'hE1;
    run_a("post_rst", 4'h3, 8'hE1, 1'b0, 4'h0, 8'h00, 1'b0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
